// File: rtl/rs_syndrome.sv
// Bit-serial RS(255,239,T=8) syndrome front end over GF(2^8), p(x)=0x11D.
// Strips the 16 parity bytes, forwards information bits and streams S0..S15.
module rs_syndrome (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bits,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bits,
  output logic       out_valid,
  output logic [7:0] synd,
  output logic [3:0] synd_idx,
  output logic       synd_valid,
  output logic       done,
  output logic       err,
  output logic       frame_err
);
  localparam int NSYN = 16;
  localparam int DLEN = 128;
  localparam logic [7:0] FILL_FULL = 8'd128;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, FIN = 2'd2, SOUT = 2'd3} state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Multiply by alpha^j; j is a loop constant at every call, so this folds to XOR gates.
  function automatic logic [7:0] gf_mul_apow(input logic [7:0] a, input int j);
    logic [7:0] r;
    r = a;
    for (int k = 0; k < NSYN - 1; k++) begin
      r = (k < j) ? gf_xtime(r) : r;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_rdy_q, byte_rdy_d;
  logic [8:0]       byte_cnt_q, byte_cnt_d;
  logic [DLEN-1:0]  dl_q, dl_d;
  logic [7:0]       fill_q, fill_d;
  logic             ferr_lat_q, ferr_lat_d;
  logic [3:0]       sidx_q, sidx_d;
  logic [7:0]       syn_q [NSYN];
  logic [7:0]       syn_d [NSYN];
  logic             out_bits_q, out_bits_d, out_valid_q, out_valid_d;
  logic [7:0]       synd_q, synd_d;
  logic [3:0]       synd_idx_q, synd_idx_d;
  logic             synd_valid_q, synd_valid_d;
  logic             done_q, done_d, err_q, err_d, frame_err_q, frame_err_d;
  logic             any_nz;
  logic [3:0]       nidx;

  assign in_ready   = (state_q == IDLE) || (state_q == RECV);
  assign out_bits   = out_bits_q;
  assign out_valid  = out_valid_q;
  assign synd       = synd_q;
  assign synd_idx   = synd_idx_q;
  assign synd_valid = synd_valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign frame_err  = frame_err_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_d       = byte_q;
    byte_rdy_d   = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    dl_d         = dl_q;
    fill_d       = fill_q;
    ferr_lat_d   = ferr_lat_q;
    sidx_d       = sidx_q;
    out_bits_d   = 1'b0;
    out_valid_d  = 1'b0;
    synd_d       = synd_q;
    synd_idx_d   = synd_idx_q;
    synd_valid_d = synd_valid_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    frame_err_d  = 1'b0;
    any_nz       = 1'b0;
    nidx         = sidx_q + 4'd1;
    // Horner step lands one edge after the byte completes, independent of state.
    for (int j = 0; j < NSYN; j++) begin
      syn_d[j] = byte_rdy_q ? (gf_mul_apow(syn_q[j], j) ^ byte_q) : syn_q[j];
      any_nz   = any_nz | (syn_q[j] != 8'h00);
    end
    case (state_q)
      IDLE, RECV: begin
        if (in_valid) begin
          state_d   = RECV;
          shreg_d   = {shreg_q[6:0], in_bits};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_d     = {shreg_q[6:0], in_bits};
            byte_rdy_d = 1'b1;
            byte_cnt_d = (byte_cnt_q == 9'h1FF) ? byte_cnt_q : byte_cnt_q + 9'd1;
          end else begin
            byte_rdy_d = 1'b0;
          end
          dl_d = {dl_q[DLEN-2:0], in_bits};
          if (fill_q == FILL_FULL) begin
            out_bits_d  = dl_q[DLEN-1];
            out_valid_d = 1'b1;
          end else begin
            fill_d = fill_q + 8'd1;
          end
        end else if (state_q == RECV) begin
          // E0: parity still in the delay line is discarded with the fill count.
          state_d    = FIN;
          fill_d     = 8'd0;
          bit_cnt_d  = 3'd0;
          ferr_lat_d = (bit_cnt_q != 3'd0) || (byte_cnt_q < 9'd17) || (byte_cnt_q > 9'd255);
        end else begin
          state_d = IDLE;
        end
      end
      FIN: begin
        state_d      = SOUT;
        sidx_d       = 4'd0;
        synd_d       = syn_q[0];
        synd_idx_d   = 4'd0;
        synd_valid_d = 1'b1;
      end
      SOUT: begin
        if (sidx_q == 4'd15) begin
          state_d      = IDLE;
          sidx_d       = 4'd0;
          synd_d       = 8'h00;
          synd_idx_d   = 4'd0;
          synd_valid_d = 1'b0;
          byte_cnt_d   = 9'd0;
          bit_cnt_d    = 3'd0;
          fill_d       = 8'd0;
          ferr_lat_d   = 1'b0;
          for (int j = 0; j < NSYN; j++) begin
            syn_d[j] = 8'h00;
          end
        end else begin
          sidx_d     = nidx;
          synd_d     = syn_q[nidx];
          synd_idx_d = nidx;
          if (nidx == 4'd15) begin
            done_d      = 1'b1;
            err_d       = any_nz;
            frame_err_d = ferr_lat_q;
          end else begin
            done_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      byte_q       <= 8'h00;
      byte_rdy_q   <= 1'b0;
      byte_cnt_q   <= 9'd0;
      dl_q         <= '0;
      fill_q       <= 8'd0;
      ferr_lat_q   <= 1'b0;
      sidx_q       <= 4'd0;
      out_bits_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      synd_q       <= 8'h00;
      synd_idx_q   <= 4'd0;
      synd_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int j = 0; j < NSYN; j++) begin
        syn_q[j] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      byte_q       <= byte_d;
      byte_rdy_q   <= byte_rdy_d;
      byte_cnt_q   <= byte_cnt_d;
      dl_q         <= dl_d;
      fill_q       <= fill_d;
      ferr_lat_q   <= ferr_lat_d;
      sidx_q       <= sidx_d;
      out_bits_q   <= out_bits_d;
      out_valid_q  <= out_valid_d;
      synd_q       <= synd_d;
      synd_idx_q   <= synd_idx_d;
      synd_valid_q <= synd_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      frame_err_q  <= frame_err_d;
      for (int j = 0; j < NSYN; j++) begin
        syn_q[j] <= syn_d[j];
      end
    end
  end
endmodule

// File: tb/tb_rs_syndrome.sv
// Randomized self-checking bench for rs_syndrome against a polynomial-evaluation
// reference model (S_j = r(alpha^j)) and a long-division RS encoder.
module tb_rs_syndrome;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_bits = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, out_bits, out_valid, synd_valid, done, err, frame_err;
  logic [7:0] synd;
  logic [3:0] synd_idx;

  rs_syndrome dut (
    .clk(clk), .reset(reset), .in_bits(in_bits), .in_valid(in_valid), .in_ready(in_ready),
    .out_bits(out_bits), .out_valid(out_valid), .synd(synd), .synd_idx(synd_idx),
    .synd_valid(synd_valid), .done(done), .err(err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] exp_tbl [255];
  logic [7:0] gpoly [17];
  logic [7:0] blk [$];
  logic [7:0] exp_syn [16];
  bit         exp_obits [$];
  bit         exp_err, exp_ferr;

  // monitor state, written only by the monitor process
  bit         mon_on = 1'b0;
  bit         obits [$];
  logic [7:0] seen [16];
  int         sv_cnt, done_cnt, rdy_low, idx_err;
  bit         err_seen, ferr_seen;

  always @(negedge clk) begin
    if (!mon_on) begin
      obits.delete();
      sv_cnt = 0; done_cnt = 0; rdy_low = 0; idx_err = 0;
      err_seen = 1'b0; ferr_seen = 1'b0;
      for (int j = 0; j < 16; j++) seen[j] = 8'hxx;
    end else begin
      if (out_valid) obits.push_back(out_bits);
      if (synd_valid) begin
        if (int'(synd_idx) != (sv_cnt % 16)) idx_err++;
        seen[synd_idx] = synd;
        sv_cnt++;
      end
      if (done) begin
        done_cnt++;
        err_seen = err;
        ferr_seen = frame_err;
      end
      if (!in_ready) rdy_low++;
    end
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [8:0] x;
    r = 8'h00;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11D;
    end
    return r;
  endfunction

  // Expected outputs for the first nbits bits of blk.
  task automatic model_block(input int nbits);
    int nb;
    nb = nbits / 8;
    exp_err = 1'b0;
    for (int j = 0; j < 16; j++) begin
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < nb; i++) s = s ^ gf_mul(blk[i], exp_tbl[(j * (nb - 1 - i)) % 255]);
      exp_syn[j] = s;
      if (s != 8'h00) exp_err = 1'b1;
    end
    exp_ferr = (nbits % 8 != 0) || (nb < 17) || (nb > 255);
    exp_obits.delete();
    for (int i = 0; i < nbits - 128; i++) begin
      logic [7:0] b;
      b = blk[i / 8];
      exp_obits.push_back(b[7 - (i % 8)]);
    end
  endtask

  // blk holds 239 message bytes on entry; 16 parity bytes are appended.
  task automatic rs_encode();
    logic [7:0] p [16];
    logic [7:0] fb;
    for (int k = 0; k < 16; k++) p[k] = 8'h00;
    for (int i = 0; i < 239; i++) begin
      fb = blk[i] ^ p[15];
      for (int k = 15; k > 0; k--) p[k] = p[k-1] ^ gf_mul(fb, gpoly[k]);
      p[0] = gf_mul(fb, gpoly[0]);
    end
    for (int k = 15; k >= 0; k--) blk.push_back(p[k]);
  endtask

  task automatic fill_random(input int n);
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic run_block(input int nbits, input bit noise, input int rst_at);
    logic [7:0] b;
    mon_on = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        break;
      end
      b = blk[i / 8];
      in_valid = 1'b1;
      in_bits  = b[7 - (i % 8)];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (rst_at < 0) begin
      for (int c = 0; c < 24; c++) begin
        @(posedge clk); #1;
        in_valid = (noise && !in_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_bits  = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({out_bits, out_valid, synd, synd_idx, synd_valid, done, err, frame_err} !== 19'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h want 0", {out_bits, out_valid, synd, synd_idx, synd_valid, done, err, frame_err});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_zero_block();
    blk.delete();
    for (int i = 0; i < 17; i++) blk.push_back(8'h00);
    run_block(136, 1'b0, -1);
    model_block(136);
    n_cmp++;
    if (obits.size() != 8 || obits != exp_obits) begin n_mis++; $display("FAIL zero_obits: got %0d bits want 8 zeros", obits.size()); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (seen[j] !== 8'h00) begin n_mis++; $display("FAIL zero_S%0d: got %h want 00", j, seen[j]); end
    end
    n_cmp++;
    if (done_cnt != 1 || err_seen !== 1'b0 || ferr_seen !== 1'b0) begin
      n_mis++; $display("FAIL zero_done: got done=%0d err=%b ferr=%b want 1 0 0", done_cnt, err_seen, ferr_seen);
    end
    n_cmp++;
    if (sv_cnt != 16 || idx_err != 0) begin n_mis++; $display("FAIL zero_svalid: got %0d cycles idxerr=%0d want 16 0", sv_cnt, idx_err); end
    n_cmp++;
    if (rdy_low != 17) begin n_mis++; $display("FAIL zero_ready_low: got %0d want 17", rdy_low); end
  endtask

  task automatic test_single_one();
    blk.delete();
    blk.push_back(8'h01);
    for (int i = 0; i < 16; i++) blk.push_back(8'h00);
    run_block(136, 1'b0, -1);
    model_block(136);
    n_cmp++;
    if (seen[0] !== 8'h01 || seen[1] !== 8'h4C) begin n_mis++; $display("FAIL one_S0S1: got %h %h want 01 4c", seen[0], seen[1]); end
    for (int j = 2; j < 16; j++) begin
      n_cmp++;
      if (seen[j] !== exp_syn[j]) begin n_mis++; $display("FAIL one_S%0d: got %h want %h", j, seen[j], exp_syn[j]); end
    end
    n_cmp++;
    if (obits != exp_obits) begin n_mis++; $display("FAIL one_obits: got %0d bits want byte 01", obits.size()); end
    n_cmp++;
    if (done_cnt != 1 || err_seen !== 1'b1 || ferr_seen !== 1'b0) begin
      n_mis++; $display("FAIL one_done: got done=%0d err=%b ferr=%b want 1 1 0", done_cnt, err_seen, ferr_seen);
    end
  endtask

  task automatic test_codeword(input bit corrupt);
    int diffs;
    fill_random(239);
    rs_encode();
    if (corrupt) blk[254] = blk[254] ^ 8'h5A;
    run_block(2040, 1'b0, -1);
    model_block(2040);
    diffs = 0;
    for (int i = 0; i < obits.size() && i < exp_obits.size(); i++) if (obits[i] != exp_obits[i]) diffs++;
    n_cmp++;
    if (obits.size() != 1912 || diffs != 0) begin n_mis++; $display("FAIL cw%0d_obits: got %0d bits %0d diffs want 1912 0", corrupt, obits.size(), diffs); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (seen[j] !== exp_syn[j] || seen[j] !== (corrupt ? 8'h5A : 8'h00)) begin
        n_mis++; $display("FAIL cw%0d_S%0d: got %h want %h", corrupt, j, seen[j], exp_syn[j]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || err_seen !== corrupt || ferr_seen !== 1'b0) begin
      n_mis++; $display("FAIL cw%0d_done: got done=%0d err=%b ferr=%b want 1 %b 0", corrupt, done_cnt, err_seen, ferr_seen, corrupt);
    end
  endtask

  task automatic test_frame_err();
    int nbits_tbl [2];
    nbits_tbl[0] = 137;
    nbits_tbl[1] = 128;
    for (int t = 0; t < 2; t++) begin
      fill_random(18);
      run_block(nbits_tbl[t], 1'b1, -1);
      model_block(nbits_tbl[t]);
      n_cmp++;
      if (done_cnt != 1 || ferr_seen !== 1'b1 || err_seen !== exp_err) begin
        n_mis++; $display("FAIL ferr%0d_done: got done=%0d ferr=%b err=%b want 1 1 %b", t, done_cnt, ferr_seen, err_seen, exp_err);
      end
      n_cmp++;
      if (obits != exp_obits) begin n_mis++; $display("FAIL ferr%0d_obits: got %0d bits want %0d", t, obits.size(), exp_obits.size()); end
      for (int j = 0; j < 16; j++) begin
        n_cmp++;
        if (seen[j] !== exp_syn[j]) begin n_mis++; $display("FAIL ferr%0d_S%0d: got %h want %h", t, j, seen[j], exp_syn[j]); end
      end
      n_cmp++;
      if (rdy_low != 17 || sv_cnt != 16) begin n_mis++; $display("FAIL ferr%0d_sout: got rdylow=%0d sv=%0d want 17 16", t, rdy_low, sv_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    fill_random(17);
    run_block(136, 1'b0, 60);
    #1;
    n_cmp++;
    if ({out_bits, out_valid, synd, synd_idx, synd_valid, done, err, frame_err} !== 19'd0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL rstmid_outputs: got %h ready=%b want 0 1", {out_bits, out_valid, synd, synd_idx, synd_valid, done, err, frame_err}, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != 0 || sv_cnt != 0) begin n_mis++; $display("FAIL rstmid_nodone: got done=%0d sv=%0d want 0 0", done_cnt, sv_cnt); end
    fill_random(17);
    run_block(136, 1'b0, -1);
    model_block(136);
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (seen[j] !== exp_syn[j]) begin n_mis++; $display("FAIL rstmid_S%0d: got %h want %h", j, seen[j], exp_syn[j]); end
    end
    n_cmp++;
    if (done_cnt != 1 || err_seen !== exp_err || ferr_seen !== 1'b0 || obits != exp_obits) begin
      n_mis++; $display("FAIL rstmid_block: got done=%0d err=%b ferr=%b bits=%0d want 1 %b 0 8", done_cnt, err_seen, ferr_seen, obits.size(), exp_err);
    end
  endtask

  initial begin
    exp_tbl[0] = 8'h01;
    for (int k = 1; k < 255; k++) exp_tbl[k] = gf_mul(exp_tbl[k-1], 8'h02);
    for (int k = 0; k < 17; k++) gpoly[k] = 8'h00;
    gpoly[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int k = 16; k > 0; k--) gpoly[k] = gpoly[k-1] ^ gf_mul(gpoly[k], exp_tbl[i]);
      gpoly[0] = gf_mul(gpoly[0], exp_tbl[i]);
    end
    test_reset();
    test_zero_block();
    test_single_one();
    test_codeword(1'b0);
    test_codeword(1'b1);
    test_frame_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
